// File: rtl/stage_memory_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
// Covers access sizes, FSM states, byte-enable constants and the writeback result record.
package stage_memory_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      HELD   = 2'd2
   } mem_state_t;

   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [4:0]  dest;
      logic [31:0] data;
      logic        addr_error;
      logic        bus_error;
   } wb_result_t;

   // Size code 3 is treated like a word access.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
      case (mem_size_t'(size))
         BYTE:    return 1'b0;
         HALF:    return lsb[0];
         default: return lsb != 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lsb);
      case (mem_size_t'(size))
         BYTE:    return BE_BYTE0 << lsb;
         HALF:    return lsb[1] ? BE_HALF_HI : BE_HALF_LO;
         default: return BE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/stage_memory_load_align.sv
// Load lane select and sign/zero extension of the returned bus word.
// Little-endian: byte lane n sits at rdata[8n+7:8n].
module load_data_align
   import stage_memory_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lsb,
   input  logic [1:0]  size,
   input  logic        unsigned_load,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign shifted   = rdata >> {lsb, 3'b000};
   assign byte_lane = shifted[7:0];
   assign half_lane = lsb[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      data = rdata;
      case (mem_size_t'(size))
         BYTE:    data = {{24{!unsigned_load && byte_lane[7]}}, byte_lane};
         HALF:    data = {{16{!unsigned_load && half_lane[15]}}, half_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/stage_memory.sv
// Memory-access pipeline stage: M register, single-outstanding req/ack bus FSM,
// LL/SC link bit and registered writeback outputs.
//
//   state  | meaning
//   IDLE   | M evaluated; a memory op drives dmem_req combinationally, others retire
//   ACCESS | request outstanding, waiting for dmem_ack or timeout
//   HELD   | access finished under stall_in; result parked in hold until release
module stage_memory
   import stage_memory_pkg::*;
#(
   parameter int WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [1:0]  ex_mem_size,
   input  logic        ex_load_unsigned,
   input  logic        ex_ll,
   input  logic        ex_sc,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_rt_data,
   input  logic        ex_reg_write,
   input  logic [4:0]  ex_dest_reg,
   input  logic [31:0] ex_dest_reg_data,
   input  logic        stall_in,
   input  logic        nullify,
   input  logic        llbit_clear,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_out,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_dest_reg,
   output logic [31:0] wb_data,
   output logic        addr_error,
   output logic        bus_error,
   output logic        llbit
);

   localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

   logic        m_valid, m_read, m_write, m_unsigned, m_ll, m_sc, m_reg_write, m_kill;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_rt, m_data;
   logic [4:0]  m_dest;

   mem_state_t  state, state_next;
   logic [CW-1:0] wait_cnt;
   wb_result_t  hold, wb, wb_next, mem_result;
   logic [31:0] load_data;
   logic        is_mem, bad_align, op_sc, op_ll, sc_fail, mem_go;
   logic        timeout, done, capture, in_flight;

   assign is_mem    = m_valid && (m_read || m_write);
   assign bad_align = misaligned(m_size, m_addr[1:0]);
   assign op_sc     = m_sc && m_write;
   assign op_ll     = m_ll && m_read;
   assign sc_fail   = op_sc && !llbit;
   assign mem_go    = (state == IDLE) && is_mem && !bad_align && !sc_fail;
   assign timeout   = (WAIT_LIMIT != 0) && (state == ACCESS) && !dmem_ack && (wait_cnt == CW'(1));
   assign done      = (mem_go || (state == ACCESS)) && (dmem_ack || timeout);
   assign capture   = !stall_out && !stall_in;
   assign in_flight = mem_go || (state != IDLE);

   load_data_align u_align (
      .rdata         (dmem_rdata),
      .lsb           (m_addr[1:0]),
      .size          (m_size),
      .unsigned_load (m_unsigned),
      .data          (load_data)
   );

   assign dmem_we    = dmem_req && m_write;
   assign dmem_addr  = {m_addr[31:2], 2'b00};
   assign dmem_be    = m_write ? store_be(m_size, m_addr[1:0]) : BE_WORD;

   always_comb begin
      dmem_wdata = m_rt;
      case (mem_size_t'(m_size))
         BYTE:    dmem_wdata = {4{m_rt[7:0]}};
         HALF:    dmem_wdata = {2{m_rt[15:0]}};
         default: dmem_wdata = m_rt;
      endcase
   end

   // Result of the bus access completing this cycle; a nullified access retires silently.
   always_comb begin
      mem_result       = '0;
      mem_result.valid = 1'b1;
      mem_result.dest  = m_dest;
      if (timeout) begin
         mem_result.bus_error = 1'b1;
      end else if (op_sc) begin
         mem_result.reg_write = 1'b1;
         mem_result.data      = 32'd1;
      end else if (m_read) begin
         mem_result.reg_write = m_reg_write;
         mem_result.data      = load_data;
      end
      if (m_kill) mem_result = '0;
   end

   always_comb begin
      wb_next = '0;
      case (state)
         IDLE: begin
            if (m_valid) begin
               if (is_mem && bad_align) begin
                  wb_next.valid      = 1'b1;
                  wb_next.dest       = m_dest;
                  wb_next.addr_error = 1'b1;
               end else if (is_mem && sc_fail) begin
                  wb_next.valid     = 1'b1;
                  wb_next.reg_write = 1'b1;
                  wb_next.dest      = m_dest;
               end else if (is_mem) begin
                  if (dmem_ack) wb_next = mem_result;
               end else begin
                  wb_next.valid     = 1'b1;
                  wb_next.reg_write = m_reg_write;
                  wb_next.dest      = m_dest;
                  wb_next.data      = m_data;
               end
            end
         end
         ACCESS:  if (done) wb_next = mem_result;
         HELD:    wb_next = hold;
         default: wb_next = '0;
      endcase
   end

   always_comb begin
      state_next = state;
      dmem_req   = 1'b0;
      stall_out  = 1'b0;
      case (state)
         IDLE: begin
            dmem_req  = mem_go;
            stall_out = mem_go && !dmem_ack;
            if (mem_go) begin
               if (!dmem_ack)    state_next = ACCESS;
               else if (stall_in) state_next = HELD;
            end
         end
         ACCESS: begin
            dmem_req  = 1'b1;
            stall_out = !done;
            if (done) state_next = stall_in ? HELD : IDLE;
         end
         HELD: begin
            stall_out = stall_in;
            if (!stall_in) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (mem_go && !dmem_ack)
            wait_cnt <= CW'(WAIT_LIMIT);
         else if ((state == ACCESS) && !dmem_ack && (wait_cnt != '0))
            wait_cnt <= wait_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid     <= 1'b0;
         m_read      <= 1'b0;
         m_write     <= 1'b0;
         m_size      <= 2'd0;
         m_unsigned  <= 1'b0;
         m_ll        <= 1'b0;
         m_sc        <= 1'b0;
         m_addr      <= '0;
         m_rt        <= '0;
         m_reg_write <= 1'b0;
         m_dest      <= '0;
         m_data      <= '0;
         m_kill      <= 1'b0;
      end else if (capture) begin
         m_valid     <= ex_valid && !nullify;
         m_read      <= ex_mem_read;
         m_write     <= ex_mem_write;
         m_size      <= ex_mem_size;
         m_unsigned  <= ex_load_unsigned;
         m_ll        <= ex_ll;
         m_sc        <= ex_sc;
         m_addr      <= ex_alu_out;
         m_rt        <= ex_rt_data;
         m_reg_write <= ex_reg_write;
         m_dest      <= ex_dest_reg;
         m_data      <= ex_dest_reg_data;
         m_kill      <= 1'b0;
      end else if (nullify && in_flight) begin
         m_kill <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb   <= '0;
         hold <= '0;
      end else begin
         if (!stall_in) wb <= wb_next;
         if (done && stall_in) hold <= mem_result;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         llbit <= 1'b0;
      else if (llbit_clear)
         llbit <= 1'b0;
      else if (done && dmem_ack && op_ll && !m_kill)
         llbit <= 1'b1;
      else if (done && dmem_ack && op_sc)
         llbit <= 1'b0;
   end

   assign wb_valid     = wb.valid;
   assign wb_reg_write = wb.reg_write;
   assign wb_dest_reg  = wb.dest;
   assign wb_data      = wb.data;
   assign addr_error   = wb.addr_error;
   assign bus_error    = wb.bus_error;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: loads, stores, LL/SC, misalignment, stall hold and timeout.
module tb_stage_memory;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_load_unsigned, ex_ll, ex_sc, ex_reg_write;
   logic [1:0]  ex_mem_size;
   logic [31:0] ex_alu_out, ex_rt_data, ex_dest_reg_data;
   logic [4:0]  ex_dest_reg;
   logic        stall_in, nullify, llbit_clear;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        stall_out, wb_valid, wb_reg_write, addr_error, bus_error, llbit;
   logic [4:0]  wb_dest_reg;
   logic [31:0] wb_data;

   int          n_vec = 0;
   int          n_err = 0;
   int          stall_cnt, req_cnt;
   logic        seen_req, seen_we;
   logic [3:0]  seen_be;
   logic [31:0] seen_addr, seen_wdata;

   always #5 clk = ~clk;

   stage_memory #(.WAIT_LIMIT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .ex_valid         (ex_valid),
      .ex_mem_read      (ex_mem_read),
      .ex_mem_write     (ex_mem_write),
      .ex_mem_size      (ex_mem_size),
      .ex_load_unsigned (ex_load_unsigned),
      .ex_ll            (ex_ll),
      .ex_sc            (ex_sc),
      .ex_alu_out       (ex_alu_out),
      .ex_rt_data       (ex_rt_data),
      .ex_reg_write     (ex_reg_write),
      .ex_dest_reg      (ex_dest_reg),
      .ex_dest_reg_data (ex_dest_reg_data),
      .stall_in         (stall_in),
      .nullify          (nullify),
      .llbit_clear      (llbit_clear),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_be          (dmem_be),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_ack         (dmem_ack),
      .stall_out        (stall_out),
      .wb_valid         (wb_valid),
      .wb_reg_write     (wb_reg_write),
      .wb_dest_reg      (wb_dest_reg),
      .wb_data          (wb_data),
      .addr_error       (addr_error),
      .bus_error        (bus_error),
      .llbit            (llbit)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic ex_idle();
      ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_size = SZ_W;
      ex_load_unsigned = 0; ex_ll = 0; ex_sc = 0; ex_alu_out = '0; ex_rt_data = '0;
      ex_reg_write = 0; ex_dest_reg = '0; ex_dest_reg_data = '0;
   endtask

   // Present one instruction for a single capture edge; returns at +1 after that edge.
   task automatic issue(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                        input logic ll, input logic sc, input logic [31:0] addr,
                        input logic [31:0] rt, input logic regw, input logic [4:0] dest,
                        input logic [31:0] data);
      ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = size;
      ex_load_unsigned = uns; ex_ll = ll; ex_sc = sc; ex_alu_out = addr; ex_rt_data = rt;
      ex_reg_write = regw; ex_dest_reg = dest; ex_dest_reg_data = data;
      @(posedge clk); #1;
      ex_idle();
   endtask

   // Bus responder: ack after wait_n non-ack cycles, with stall_in = hold_in on the ack cycle.
   task automatic bus_cycle(input int wait_n, input logic [31:0] rd, input logic hold_in);
      stall_cnt = 0;
      for (int i = 0; i <= wait_n; i++) begin
         dmem_ack   = (i == wait_n);
         dmem_rdata = rd;
         stall_in   = (i == wait_n) ? hold_in : 1'b0;
         #4;
         if (stall_out) stall_cnt++;
         seen_req = dmem_req; seen_we = dmem_we; seen_be = dmem_be;
         seen_addr = dmem_addr; seen_wdata = dmem_wdata;
         @(posedge clk); #1;
      end
      dmem_ack = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; stall_in = 0; nullify = 0; llbit_clear = 0;
      dmem_ack = 0; dmem_rdata = '0;
      ex_idle();
      @(posedge clk); @(posedge clk); #1;
      check("rst_wb_valid",  32'(wb_valid), 32'd0);
      check("rst_stall_out", 32'(stall_out), 32'd0);
      check("rst_dmem_req",  32'(dmem_req), 32'd0);
      check("rst_llbit",     32'(llbit), 32'd0);
      check("rst_errors",    32'({addr_error, bus_error, dmem_we}), 32'd0);
      reset = 0;
      @(posedge clk); #1;

      // lw 0x100, ack after 3 cycles
      issue(1, 0, SZ_W, 0, 0, 0, 32'h100, 32'h0, 1, 5'd5, 32'h0);
      bus_cycle(3, 32'hDEADBEEF, 0);
      check("lw_stall_cycles", 32'(stall_cnt), 32'd3);
      check("lw_req_we",  32'({seen_req, seen_we}), 32'b10);
      check("lw_addr",    seen_addr, 32'h100);
      check("lw_be",      32'(seen_be), 32'hF);
      check("lw_wb",      32'({wb_valid, wb_reg_write, wb_dest_reg}), 32'b1_1_00101);
      check("lw_data",    wb_data, 32'hDEADBEEF);

      // lb / lbu / lh on byte 3 / half 1, zero wait
      issue(1, 0, SZ_B, 0, 0, 0, 32'h103, 32'h0, 1, 5'd6, 32'h0);
      bus_cycle(0, 32'h80FF_0000, 0);
      check("lb_stall", 32'(stall_cnt), 32'd0);
      check("lb_data",  wb_data, 32'hFFFFFF80);
      issue(1, 0, SZ_B, 1, 0, 0, 32'h103, 32'h0, 1, 5'd6, 32'h0);
      bus_cycle(0, 32'h80FF_0000, 0);
      check("lbu_data", wb_data, 32'h00000080);
      issue(1, 0, SZ_H, 0, 0, 0, 32'h102, 32'h0, 1, 5'd7, 32'h0);
      bus_cycle(1, 32'h80FF_0000, 0);
      check("lh_data",  wb_data, 32'hFFFF80FF);

      // sh / sb lane placement
      issue(0, 1, SZ_H, 0, 0, 0, 32'h202, 32'h1234ABCD, 0, 5'd0, 32'h0);
      bus_cycle(1, 32'h0, 0);
      check("sh_be",    32'(seen_be), 32'hC);
      check("sh_wdata", seen_wdata, 32'hABCDABCD);
      check("sh_we",    32'(seen_we), 32'd1);
      check("sh_addr",  seen_addr, 32'h200);
      check("sh_wb",    32'({wb_valid, wb_reg_write}), 32'b10);
      issue(0, 1, SZ_B, 0, 0, 0, 32'h301, 32'h00000077, 0, 5'd0, 32'h0);
      bus_cycle(0, 32'h0, 0);
      check("sb_be",    32'(seen_be), 32'h2);
      check("sb_wdata", seen_wdata, 32'h77777777);

      // ll / sc success / sc fail
      issue(1, 0, SZ_W, 0, 1, 0, 32'h40, 32'h0, 1, 5'd8, 32'h0);
      bus_cycle(0, 32'h11112222, 0);
      check("ll_data",  wb_data, 32'h11112222);
      check("ll_llbit", 32'(llbit), 32'd1);
      issue(0, 1, SZ_W, 0, 0, 1, 32'h40, 32'hCAFEF00D, 1, 5'd9, 32'h0);
      bus_cycle(1, 32'h0, 0);
      check("sc_req_we", 32'({seen_req, seen_we}), 32'b11);
      check("sc_wdata",  seen_wdata, 32'hCAFEF00D);
      check("sc_wb",     32'({wb_valid, wb_reg_write}), 32'b11);
      check("sc_data",   wb_data, 32'd1);
      check("sc_llbit",  32'(llbit), 32'd0);
      issue(0, 1, SZ_W, 0, 0, 1, 32'h40, 32'hCAFEF00D, 1, 5'd9, 32'h0);
      #4;
      check("sc2_no_req", 32'({dmem_req, stall_out}), 32'd0);
      @(posedge clk); #1;
      check("sc2_wb",   32'({wb_valid, wb_reg_write}), 32'b11);
      check("sc2_data", wb_data, 32'd0);

      // llbit_clear wins over a same-cycle LL completion
      issue(1, 0, SZ_W, 0, 1, 0, 32'h44, 32'h0, 1, 5'd8, 32'h0);
      llbit_clear = 1;
      bus_cycle(0, 32'h0, 0);
      llbit_clear = 0;
      check("ll_clear_llbit", 32'(llbit), 32'd0);

      // misaligned word load
      issue(1, 0, SZ_W, 0, 0, 0, 32'h101, 32'h0, 1, 5'd4, 32'h0);
      #4;
      check("mis_no_req", 32'({dmem_req, stall_out}), 32'd0);
      @(posedge clk); #1;
      check("mis_wb", 32'({wb_valid, addr_error, wb_reg_write, bus_error}), 32'b1100);
      check("mis_llbit", 32'(llbit), 32'd0);
      @(posedge clk); #1;
      check("mis_clear", 32'({wb_valid, addr_error}), 32'd0);

      // non-memory op: result appears two edges after presentation
      issue(0, 0, SZ_W, 0, 0, 0, 32'h0, 32'h0, 1, 5'd3, 32'h000055AA);
      #4;
      check("alu_not_yet", 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
      check("alu_wb",   32'({wb_valid, wb_reg_write, wb_dest_reg}), 32'b1_1_00011);
      check("alu_data", wb_data, 32'h000055AA);
      @(posedge clk); #1;

      // ack under stall_in: data parked, delivered on release
      issue(1, 0, SZ_W, 0, 0, 0, 32'h104, 32'h0, 1, 5'd10, 32'h0);
      bus_cycle(0, 32'h0BADF00D, 1);
      dmem_rdata = 32'hFFFFFFFF;
      #4;
      check("held_stall", 32'({stall_out, dmem_req}), 32'b10);
      check("held_no_wb", 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
      stall_in = 0;
      #4;
      check("held_release", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      check("held_wb",   32'({wb_valid, wb_reg_write, wb_dest_reg}), 32'b1_1_01010);
      check("held_data", wb_data, 32'h0BADF00D);

      // nullify at capture: nothing issued
      nullify = 1;
      issue(1, 0, SZ_W, 0, 0, 0, 32'h108, 32'h0, 1, 5'd11, 32'h0);
      nullify = 0;
      #4;
      check("null_no_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      check("null_no_wb", 32'(wb_valid), 32'd0);

      // nullify while in flight: access completes, result dropped
      issue(1, 0, SZ_W, 0, 0, 0, 32'h10C, 32'h0, 1, 5'd12, 32'h0);
      nullify = 1;
      #4;
      @(posedge clk); #1;
      nullify = 0;
      bus_cycle(1, 32'h12345678, 0);
      check("kill_req_held", 32'(seen_req), 32'd1);
      check("kill_no_wb",    32'(wb_valid), 32'd0);

      // timeout: no ack, WAIT_LIMIT=4 access cycles after the request cycle
      issue(1, 0, SZ_W, 0, 0, 0, 32'h110, 32'h0, 1, 5'd13, 32'h0);
      req_cnt = 0; stall_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         #4;
         if (dmem_req) req_cnt++;
         if (stall_out) stall_cnt++;
         @(posedge clk); #1;
         if (wb_valid) break;
      end
      check("to_req_cycles",   32'(req_cnt), 32'd5);
      check("to_stall_cycles", 32'(stall_cnt), 32'd4);
      check("to_wb", 32'({wb_valid, bus_error, wb_reg_write, addr_error}), 32'b1100);
      #4;
      check("to_req_dropped", 32'({dmem_req, stall_out}), 32'd0);
      @(posedge clk); #1;
      check("to_clear", 32'({wb_valid, bus_error}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
